dcache_flush_engine: RTL

Hardware write-back engine for the direct-mapped data cache in the memory-access stage. On a start pulse it walks all cache lines, reads each line's valid bit, tag and 32-bit data, and writes every valid line back to main RAM as two 16-bit halfword writes. It can optionally invalidate each line as it goes. It sits between the data cache arrays and the unified RAM port, and is used before software or the bench inspects RAM contents after a run.

---
 rtl/dcache_flush_engine.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dcache_flush_engine.sv
// rtl/dcache_flush_engine.sv - walks the direct-mapped data cache and writes valid lines back to halfword RAM
module dcache_flush_engine #(
  parameter int LINES      = 256,
  parameter int TAG_W      = 22,
  parameter int RAM_DEPTH  = 8192,
  parameter int RAM_ADDR_W = 13,
  localparam int IDX_W     = $clog2(LINES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  invalidate,
  output logic                  busy,
  output logic                  done,
  output logic                  oob,
  output logic                  cache_rd_en,
  output logic [IDX_W-1:0]      cache_index,
  input  logic                  cache_valid,
  input  logic [TAG_W-1:0]      cache_tag,
  input  logic [31:0]           cache_data,
  output logic                  cache_inv_en,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [15:0]           ram_wdata,
  input  logic                  ram_ready
);

  localparam int BADDR_W = TAG_W + IDX_W + 2;
  localparam logic [BADDR_W-1:0] BYTE_LIMIT = BADDR_W'(2 * RAM_DEPTH);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(LINES - 1);

  typedef enum logic [2:0] {IDLE, READ, CHECK, WR_LO, WR_HI, DONE} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx;
  logic                    inv_q;
  logic                    oob_q;
  logic [31:0]             data_q;
  logic [RAM_ADDR_W-1:0]   haddr_q;
  logic [BADDR_W-1:0]      byte_addr;
  logic                    in_range;
  logic                    last_line;
  logic                    do_write;

  // Cache read data is only meaningful in CHECK, the cycle after the READ strobe.
  assign byte_addr = {cache_tag, idx, 2'b00};
  assign in_range  = byte_addr < BYTE_LIMIT;
  assign last_line = idx == LAST_IDX;
  assign do_write  = cache_valid && in_range;
  assign oob       = oob_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    state_nxt = CHECK;
      CHECK: begin
        if (do_write)       state_nxt = WR_LO;
        else if (last_line) state_nxt = DONE;
        else                state_nxt = READ;
      end
      WR_LO:   if (ram_ready) state_nxt = WR_HI;
      WR_HI:   if (ram_ready) state_nxt = last_line ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx     <= '0;
      inv_q   <= 1'b0;
      oob_q   <= 1'b0;
      data_q  <= '0;
      haddr_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          idx <= '0;
          if (start) begin
            oob_q <= 1'b0;
            inv_q <= invalidate;
          end
        end
        CHECK: begin
          data_q  <= cache_data;
          haddr_q <= byte_addr[RAM_ADDR_W:1];
          if (cache_valid && !in_range) oob_q <= 1'b1;
          if (!do_write && !last_line) idx <= idx + IDX_W'(1);
        end
        WR_HI: begin
          if (ram_ready && !last_line) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    cache_rd_en  = 1'b0;
    cache_index  = '0;
    cache_inv_en = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    unique case (state)
      READ: begin
        busy        = 1'b1;
        cache_rd_en = 1'b1;
        cache_index = idx;
      end
      CHECK: busy = 1'b1;
      WR_LO: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = haddr_q;
        ram_wdata = data_q[15:0];
      end
      WR_HI: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = haddr_q + RAM_ADDR_W'(1);
        ram_wdata = data_q[31:16];
        // Invalidate only once the high half is committed, so a stalled line stays valid.
        if (ram_ready && inv_q) begin
          cache_inv_en = 1'b1;
          cache_index  = idx;
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
